// File: rtl/dropout_pkg.sv
// Shared constants and helpers for the streaming dropout unit: LFSR taps,
// the per-lane seed mixing constant, and the next-state / seed-mix functions.
package dropout_pkg;

   localparam logic [31:0] LANE_MIX = 32'h9E37_79B9;
   // Tap masks: 32-bit uses bits 31,21,1,0; 16-bit uses bits 15,14,12,3
   localparam logic [31:0] TAPS32   = 32'h8020_0003;
   localparam logic [15:0] TAPS16   = 16'hD008;

   // Fibonacci step, shift right with the feedback bit entering at the MSB
   function automatic logic [31:0] lfsr_next(input logic [31:0] state, input int unsigned width);
      logic [31:0] nxt;
      if (width == 16)
         nxt = {16'h0000, ^(state[15:0] & TAPS16), state[15:1]};
      else
         nxt = {^(state & TAPS32), state[31:1]};
      return nxt;
   endfunction

   function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned idx);
      logic [31:0] prod;
      prod = 32'(idx) * LANE_MIX;
      return base ^ prod;
   endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// Per-lane random word generator: seedable, advance-enabled LFSR whose state
// is never allowed to become zero.
module dropout_lfsr
   import dropout_pkg::*;
#(
   parameter int unsigned LFSR_WIDTH   = 32,
   parameter logic [31:0] SEED_DEFAULT = 32'hACE1_0001,
   parameter int unsigned LANE_IDX     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [LFSR_WIDTH-1:0] seed,
   input  logic                  advance,
   output logic [LFSR_WIDTH-1:0] state
);

   localparam logic [31:0]           RST_MIX   = lane_seed(SEED_DEFAULT, LANE_IDX);
   localparam logic [LFSR_WIDTH-1:0] RST_TRUNC = RST_MIX[LFSR_WIDTH-1:0];
   localparam logic [LFSR_WIDTH-1:0] RST_STATE = (RST_TRUNC == '0) ? LFSR_WIDTH'(1) : RST_TRUNC;

   logic [31:0]           load_mix;
   logic [31:0]           step;
   logic [LFSR_WIDTH-1:0] load_val;
   logic [LFSR_WIDTH-1:0] state_reg;
   logic [LFSR_WIDTH-1:0] state_next;

   assign load_mix = lane_seed(32'(seed), LANE_IDX);
   assign step     = lfsr_next(32'(state_reg), LFSR_WIDTH);

   // Load beats advance so a same-cycle beat still sees the pre-load word
   always_comb begin
      load_val = load_mix[LFSR_WIDTH-1:0];
      if (load_val == '0)
         load_val = LFSR_WIDTH'(1);
      state_next = state_reg;
      if (load)
         state_next = load_val;
      else if (advance)
         state_next = step[LFSR_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= RST_STATE;
      else
         state_reg <= state_next;
   end

   assign state = state_reg;

endmodule

// File: rtl/dropout_stream.sv
// Multi-lane inverted-dropout stage: S1 samples data, per-lane keep masks and
// beat controls; S2 scales/saturates kept lanes and drives the output port.
module dropout_stream
   import dropout_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned LANES        = 4,
   parameter int unsigned LFSR_WIDTH   = 32,
   parameter int unsigned FRAC_BITS    = 8,
   parameter logic [31:0] SEED_DEFAULT = 32'hACE1_0001
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             training_mode,
   input  logic [LFSR_WIDTH-1:0]            thresh,
   input  logic [DATA_WIDTH+FRAC_BITS-1:0]  scale,
   input  logic                             seed_load,
   input  logic [LFSR_WIDTH-1:0]            seed,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [LANES*DATA_WIDTH-1:0]      s_data,
   input  logic                             s_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [LANES*DATA_WIDTH-1:0]      m_data,
   output logic [LANES-1:0]                 m_mask,
   output logic                             m_last,
   output logic [31:0]                      drop_count
);

   localparam int unsigned SCALE_W = DATA_WIDTH + FRAC_BITS;
   localparam int unsigned PROD_W  = 2*DATA_WIDTH + FRAC_BITS;
   localparam logic [DATA_WIDTH-1:0] DATA_MAX = '1;

   logic [LFSR_WIDTH-1:0]       lfsr_state [LANES];
   logic [LANES-1:0]            keep;
   logic                        accept;
   logic                        lfsr_adv;
   logic                        s2_ready;
   logic [31:0]                 drop_pop;
   logic [32:0]                 drop_sum;
   logic [LANES*DATA_WIDTH-1:0] scaled;

   logic                        s1_valid_reg;
   logic [LANES*DATA_WIDTH-1:0] s1_data_reg;
   logic [LANES-1:0]            s1_keep_reg;
   logic                        s1_last_reg;
   logic                        s1_train_reg;
   logic [SCALE_W-1:0]          s1_scale_reg;

   logic                        m_valid_reg;
   logic [LANES*DATA_WIDTH-1:0] m_data_reg;
   logic [LANES-1:0]            m_mask_reg;
   logic                        m_last_reg;
   logic [31:0]                 drop_count_reg;

   // Readiness looks only at occupancy and m_ready, never at s_valid
   assign s2_ready = !m_valid_reg || m_ready;
   assign s_ready  = !s1_valid_reg || s2_ready;
   assign accept   = s_valid && s_ready;
   assign lfsr_adv = accept && training_mode;

   for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
      logic [DATA_WIDTH-1:0] lane_d;
      logic [PROD_W-1:0]     prod;
      logic [PROD_W-1:0]     shifted;
      logic [DATA_WIDTH-1:0] sat_d;

      dropout_lfsr #(
         .LFSR_WIDTH   (LFSR_WIDTH),
         .SEED_DEFAULT (SEED_DEFAULT),
         .LANE_IDX     (gi)
      ) u_lfsr (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (seed_load),
         .seed    (seed),
         .advance (lfsr_adv),
         .state   (lfsr_state[gi])
      );

      assign keep[gi] = !training_mode || (lfsr_state[gi] >= thresh);

      assign lane_d  = s1_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign prod    = PROD_W'(lane_d) * PROD_W'(s1_scale_reg);
      assign shifted = prod >> FRAC_BITS;
      assign sat_d   = (|shifted[PROD_W-1:DATA_WIDTH]) ? DATA_MAX : shifted[DATA_WIDTH-1:0];
      assign scaled[gi*DATA_WIDTH +: DATA_WIDTH] =
         !s1_train_reg ? lane_d : (s1_keep_reg[gi] ? sat_d : '0);
   end

   always_comb begin
      drop_pop = '0;
      for (int i = 0; i < LANES; i++)
         drop_pop = drop_pop + {31'b0, ~keep[i]};
   end

   assign drop_sum = {1'b0, drop_count_reg} + {1'b0, drop_pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         s1_keep_reg  <= '0;
         s1_last_reg  <= 1'b0;
         s1_train_reg <= 1'b0;
         s1_scale_reg <= '0;
      end else if (s_ready) begin
         s1_valid_reg <= s_valid;
         if (s_valid) begin
            s1_data_reg  <= s_data;
            s1_keep_reg  <= keep;
            s1_last_reg  <= s_last;
            s1_train_reg <= training_mode;
            s1_scale_reg <= scale;
         end
      end
   end

   // Output registers only change when the downstream can take a new beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
         m_mask_reg  <= '0;
         m_last_reg  <= 1'b0;
      end else if (s2_ready) begin
         m_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            m_data_reg <= scaled;
            m_mask_reg <= s1_keep_reg;
            m_last_reg <= s1_last_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_count_reg <= '0;
      else if (seed_load)
         drop_count_reg <= '0;
      else if (accept)
         drop_count_reg <= drop_sum[32] ? '1 : drop_sum[31:0];
   end

   assign m_valid    = m_valid_reg;
   assign m_data     = m_data_reg;
   assign m_mask     = m_mask_reg;
   assign m_last     = m_last_reg;
   assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_dropout_stream.sv
// Directed bench for dropout_stream: hand-computed vector table plus short
// sequences for backpressure, reseeding and mid-stream reset.
module tb_dropout_stream;

   localparam int LN = 4;
   localparam logic [31:0] SEED_DEF = 32'hACE1_0001;
   localparam logic [31:0] MIX      = 32'h9E37_79B9;

   logic        clk;
   logic        rst_n;
   logic        training_mode;
   logic [31:0] thresh;
   logic [15:0] scale;
   logic        seed_load;
   logic [31:0] seed;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [3:0]  m_mask;
   logic        m_last;
   logic [31:0] drop_count;

   dropout_stream #(
      .DATA_WIDTH   (8),
      .LANES        (LN),
      .LFSR_WIDTH   (32),
      .FRAC_BITS    (8),
      .SEED_DEFAULT (SEED_DEF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .training_mode (training_mode),
      .thresh        (thresh),
      .scale         (scale),
      .seed_load     (seed_load),
      .seed          (seed),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_last        (s_last),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_mask        (m_mask),
      .m_last        (m_last),
      .drop_count    (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  mask;
      logic        last;
   } beat_t;

   typedef struct {
      logic        tr;
      logic [31:0] th;
      logic [15:0] sc;
      logic [31:0] d;
      logic        lst;
      logic [31:0] ed;
      logic [3:0]  em;
   } vec_t;

   beat_t       exp_q[$];
   logic [3:0]  mask_log[$];
   logic [3:0]  exp_mask_log[$];
   logic [31:0] model_lfsr [LN];
   logic [31:0] exp_drop;
   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          out_cnt = 0;

   function automatic logic [31:0] m_step(input logic [31:0] s);
      return {s[31] ^ s[21] ^ s[1] ^ s[0], s[31:1]};
   endfunction

   function automatic logic [31:0] m_seed(input logic [31:0] base, input int i);
      logic [31:0] v;
      v = base ^ (32'(i) * MIX);
      if (v == 32'h0) v = 32'h1;
      return v;
   endfunction

   function automatic logic [7:0] sat_scale(input logic [7:0] d, input logic [15:0] sc);
      logic [31:0] p;
      p = (32'(d) * 32'(sc)) >> 8;
      return (p > 32'd255) ? 8'hFF : p[7:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vec_cnt++;
      if (act !== req) begin
         err_cnt++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < LN; i++) model_lfsr[i] = m_seed(SEED_DEF, i);
      exp_drop = 32'h0;
   endtask

   // Scoreboard: every transferred output beat must match the oldest expectation
   always @(negedge clk) begin : monitor
      beat_t e;
      if (rst_n && m_valid && m_ready) begin
         out_cnt++;
         mask_log.push_back(m_mask);
         if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_beat: got data %h mask %h, required no beat", m_data, m_mask);
         end else begin
            e = exp_q.pop_front();
            check("out_beat", {27'h0, m_last, m_mask, m_data}, {27'h0, e.last, e.mask, e.data});
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_beat(input logic tr, input logic [31:0] th, input logic [15:0] sc,
                            input logic [31:0] d, input logic lst,
                            input logic ld, input logic [31:0] ld_seed,
                            input logic hand, input logic [31:0] hd, input logic [3:0] hm);
      beat_t      e;
      logic [3:0] km;
      int         n;
      int         drops;
      training_mode = tr;
      thresh        = th;
      scale         = sc;
      s_data        = d;
      s_last        = lst;
      seed_load     = ld;
      seed          = ld_seed;
      s_valid       = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 64) begin
         n++;
         @(negedge clk);
      end
      if (!s_ready) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL accept_timeout: s_ready got 0, required 1");
      end else begin
         drops = 0;
         for (int i = 0; i < LN; i++) begin
            km[i] = !tr || (model_lfsr[i] >= th);
            if (!km[i]) drops++;
         end
         e.last = lst;
         if (hand) begin
            e.data = hd;
            e.mask = hm;
         end else begin
            e.mask = km;
            for (int i = 0; i < LN; i++)
               e.data[i*8 +: 8] = !tr ? d[i*8 +: 8] : (km[i] ? sat_scale(d[i*8 +: 8], sc) : 8'h00);
         end
         exp_q.push_back(e);
         exp_mask_log.push_back(e.mask);
         if (ld) begin
            exp_drop = 32'h0;
            for (int i = 0; i < LN; i++) model_lfsr[i] = m_seed(ld_seed, i);
         end else begin
            exp_drop = (exp_drop > 32'hFFFF_FFFF - 32'(drops)) ? 32'hFFFF_FFFF : exp_drop + 32'(drops);
            if (tr)
               for (int i = 0; i < LN; i++) model_lfsr[i] = m_step(model_lfsr[i]);
         end
      end
      @(posedge clk);
      #1;
      s_valid   = 1'b0;
      seed_load = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic load_seed(input logic [31:0] sd);
      seed_load = 1'b1;
      seed      = sd;
      @(posedge clk);
      #1;
      seed_load = 1'b0;
      exp_drop  = 32'h0;
      for (int i = 0; i < LN; i++) model_lfsr[i] = m_seed(sd, i);
   endtask

   vec_t        tbl[8];
   logic [31:0] bp_data[4];
   logic        bp_last[4];
   logic [31:0] rep_d[16];
   logic [3:0]  first_masks[16];
   logic [63:0] held;
   logic        held_valid;
   int          idx;
   int          mark;
   int          out_mark;
   logic [31:0] drop_start;
   logic [31:0] delta;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 32'h0000_0000, 16'h0200, 32'h4030_2010, 1'b0, 32'h4030_2010, 4'hF};
      tbl[1] = '{1'b1, 32'h0000_0000, 16'h0200, 32'h9080_7F30, 1'b1, 32'hFFFF_FE60, 4'hF};
      tbl[2] = '{1'b1, 32'hFFFF_FFFF, 16'h0200, 32'h4433_2211, 1'b0, 32'h0000_0000, 4'h0};
      tbl[3] = '{1'b1, 32'h0000_0000, 16'h0100, 32'h01EF_CDAB, 1'b1, 32'h01EF_CDAB, 4'hF};
      tbl[4] = '{1'b1, 32'h0000_0000, 16'h0080, 32'h0180_FF03, 1'b0, 32'h0040_7F01, 4'hF};
      tbl[5] = '{1'b1, 32'h0000_0000, 16'hFFFF, 32'hFF02_0001, 1'b1, 32'hFFFF_00FF, 4'hF};
      tbl[6] = '{1'b0, 32'hFFFF_FFFF, 16'h0000, 32'hFF00_A55A, 1'b0, 32'hFF00_A55A, 4'hF};
      tbl[7] = '{1'b1, 32'h0000_0000, 16'h0180, 32'h0164_AA0A, 1'b1, 32'h0196_FF0F, 4'hF};

      rst_n = 1'b0; training_mode = 1'b0; thresh = '0; scale = '0; seed_load = 1'b0;
      seed = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {27'h0, m_valid, m_mask, m_last, m_data}, 64'h0);
      check("reset_drop_count", 64'(drop_count), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_s_ready", 64'(s_ready), 64'h1);
      @(posedge clk);
      #1;

      // Single beats from the table, each with a latency check
      for (int v = 0; v < 8; v++) begin
         send_beat(tbl[v].tr, tbl[v].th, tbl[v].sc, tbl[v].d, tbl[v].lst, 1'b0, 32'h0,
                   1'b1, tbl[v].ed, tbl[v].em);
         @(negedge clk);
         check("latency_cycle1_idle", 64'(m_valid), 64'h0);
         @(negedge clk);
         check("latency_cycle2_valid", 64'(m_valid), 64'h1);
         check("table_drop_count", 64'(drop_count), 64'(exp_drop));
         $display("vec %0d: train=%0b in=%h expected out=%h mask=%h", v, tbl[v].tr, tbl[v].d, tbl[v].ed, tbl[v].em);
         @(posedge clk);
         #1;
      end
      drain();

      // Random stream at half-probability dropping
      drop_start = drop_count;
      for (int b = 0; b < 1024; b++)
         send_beat(1'b1, 32'h8000_0000, 16'h0200, $urandom, b[0], 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      drain();
      check("random_drop_count", 64'(drop_count), 64'(exp_drop));
      delta = drop_count - drop_start;
      check("random_drop_range", 64'((delta >= 32'd1848) && (delta <= 32'd2248)), 64'h1);
      $display("random stream: 1024 beats, %0d lanes dropped", delta);

      // Backpressure: six stalled cycles with input offered
      bp_data[0] = 32'h0403_0201; bp_last[0] = 1'b0;
      bp_data[1] = 32'h1413_1211; bp_last[1] = 1'b1;
      bp_data[2] = 32'h2423_2221; bp_last[2] = 1'b0;
      bp_data[3] = 32'h3433_3231; bp_last[3] = 1'b1;
      out_mark = out_cnt;
      m_ready = 1'b0;
      idx = 0;
      held_valid = 1'b0;
      held = '0;
      for (int c = 0; c < 6; c++) begin
         training_mode = 1'b0;
         s_valid = 1'b1;
         s_data  = bp_data[idx];
         s_last  = bp_last[idx];
         @(negedge clk);
         if (m_valid) begin
            if (!held_valid) begin
               held = {27'h0, m_last, m_mask, m_data};
               held_valid = 1'b1;
            end else begin
               check("stall_outputs_stable", {27'h0, m_last, m_mask, m_data}, held);
            end
         end
         if (s_valid && s_ready) begin
            exp_q.push_back('{bp_data[idx], 4'hF, bp_last[idx]});
            idx++;
         end
         @(posedge clk);
         #1;
      end
      check("bp_accepted", 64'(idx), 64'd2);
      check("bp_s_ready_low", 64'(s_ready), 64'h0);
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int k = 2; k < 4; k++)
         send_beat(1'b0, 32'h0, 16'h0100, bp_data[k], bp_last[k], 1'b0, 32'h0, 1'b1, bp_data[k], 4'hF);
      drain();
      check("bp_beats_out", 64'(out_cnt - out_mark), 64'd4);
      $display("backpressure: %0d beats delivered", out_cnt - out_mark);

      // Same seed and beats twice must reproduce the mask sequence
      load_seed(32'h1234_5678);
      check("seed_load_clears_drop", 64'(drop_count), 64'h0);
      for (int b = 0; b < 16; b++) rep_d[b] = $urandom;
      mark = exp_mask_log.size();
      for (int b = 0; b < 16; b++)
         send_beat(1'b1, 32'h8000_0000, 16'h0200, rep_d[b], 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      drain();
      for (int b = 0; b < 16; b++) first_masks[b] = exp_mask_log[mark + b];
      load_seed(32'h1234_5678);
      mark = mask_log.size();
      for (int b = 0; b < 16; b++)
         send_beat(1'b1, 32'h8000_0000, 16'h0200, rep_d[b], 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      drain();
      for (int b = 0; b < 16; b++)
         check("repro_mask", 64'(mask_log[mark + b]), 64'(first_masks[b]));
      $display("reseed repeat: 16 beats compared");

      // Zero seed still yields nonzero words: thresh 1 keeps every lane
      load_seed(32'h0);
      send_beat(1'b1, 32'h0000_0001, 16'h0100, 32'h5566_7788, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      drain();
      check("seed_zero_nonzero", 64'(mask_log[mask_log.size() - 1]), 64'hF);

      // seed_load with an accepted all-drop beat: counter clear wins
      send_beat(1'b1, 32'hFFFF_FFFF, 16'h0200, 32'h0102_0304, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b0, 32'h0, 4'h0);
      drain();
      check("load_clear_wins", 64'(drop_count), 64'h0);
      send_beat(1'b1, 32'h8000_0000, 16'h0200, 32'hA0B0_C0D0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      drain();

      // Mid-stream reset with two beats in flight
      send_beat(1'b1, 32'hFFFF_FFFF, 16'h0200, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      drain();
      m_ready = 1'b0;
      send_beat(1'b1, 32'h0, 16'h0200, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      send_beat(1'b1, 32'h0, 16'h0200, 32'h3333_3333, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      check("pre_reset_drop_count", 64'(drop_count), 64'(exp_drop));
      rst_n = 1'b0;
      #1;
      check("async_reset_m_valid", 64'(m_valid), 64'h0);
      check("async_reset_drop_count", 64'(drop_count), 64'h0);
      exp_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_reset_idle", 64'({m_valid, s_ready}), 64'h1);
      end
      @(posedge clk);
      #1;
      for (int b = 0; b < 8; b++)
         send_beat(1'b1, 32'h8000_0000, 16'h0200, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      drain();
      check("post_reset_drop_count", 64'(drop_count), 64'(exp_drop));
      $display("mid-stream reset: 8 beats after release");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
